// File: rtl/seg_pair_checker.sv
// ---------------------------------------------------------------------------
// seg_pair_checker
//   Receive-side monitor for a two-digit 7-segment display bus. On each
//   sample strobe both segment patterns are decoded back to BCD and to a
//   binary value 0..99. Successive legal samples are expected to form a
//   mod-100 up-count. Illegal patterns and sequence breaks are flagged and
//   counted in a saturating error counter.
//
//   Configuration macro:
//     SEG_ACTIVE_LOW_EN  defined: segment inputs are inverted before decoding
//                        (0 = lit, common-anode). Undefined: 1 = lit.
//
//   Parameters:
//     ERR_W       width of the saturating error counter
//
//   Ports:
//     clk         system clock, rising edge
//     rst         asynchronous reset, active-low
//     sample      one-cycle strobe, capture seg_ones/seg_tens this cycle
//     seg_ones    ones-digit segments {g,f,e,d,c,b,a}
//     seg_tens    tens-digit segments {g,f,e,d,c,b,a}
//     clr_err     synchronous clear of err_count (wins over a new error)
//     digit_ones  decoded ones digit (BCD)
//     digit_tens  decoded tens digit (BCD)
//     value       tens*10 + ones
//     valid       1-cycle pulse: new legal value captured
//     pat_err     1-cycle pulse: either pattern is not a legal digit
//     seq_err     1-cycle pulse: legal value but not previous+1 mod 100
//     locked      high while a reference value is held (TRACK)
//     err_count   saturating count of pat_err/seq_err events
// ---------------------------------------------------------------------------
module seg_pair_checker #(
    parameter int unsigned ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample,
    input  logic [6:0]       seg_ones,
    input  logic [6:0]       seg_tens,
    input  logic             clr_err,
    output logic [3:0]       digit_ones,
    output logic [3:0]       digit_tens,
    output logic [6:0]       value,
    output logic             valid,
    output logic             pat_err,
    output logic             seq_err,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic {SYNC, TRACK} state_t;

    state_t           state_q, state_d;
    logic [6:0]       ones_raw, tens_raw;
    logic             ones_ok, tens_ok;
    logic [3:0]       ones_dec, tens_dec;
    logic [6:0]       new_value, expected;
    logic [3:0]       ones_d, tens_d;
    logic [6:0]       value_d;
    logic             valid_d, pat_d, seq_d;
    logic [ERR_W-1:0] err_d;

`ifdef SEG_ACTIVE_LOW_EN
    assign ones_raw = ~seg_ones;
    assign tens_raw = ~seg_tens;
`else
    assign ones_raw = seg_ones;
    assign tens_raw = seg_tens;
`endif

    // Returns {legal, digit}; digit is 0 for illegal patterns.
    function automatic logic [4:0] seg_decode(input logic [6:0] p);
        case (p)
            7'b0111111: return {1'b1, 4'd0};
            7'b0000110: return {1'b1, 4'd1};
            7'b1011011: return {1'b1, 4'd2};
            7'b1001111: return {1'b1, 4'd3};
            7'b1100110: return {1'b1, 4'd4};
            7'b1101101: return {1'b1, 4'd5};
            7'b1111101: return {1'b1, 4'd6};
            7'b0000111: return {1'b1, 4'd7};
            7'b1111111: return {1'b1, 4'd8};
            7'b1101111: return {1'b1, 4'd9};
            default:    return {1'b0, 4'd0};
        endcase
    endfunction

    assign {ones_ok, ones_dec} = seg_decode(ones_raw);
    assign {tens_ok, tens_dec} = seg_decode(tens_raw);

    // tens*8 + tens*2 + ones; max 99 fits in 7 bits
    assign new_value = {tens_dec, 3'b000} + {2'b00, tens_dec, 1'b0} + {3'b000, ones_dec};
    assign expected  = (value == 7'd99) ? 7'd0 : value + 7'd1;

    always_comb begin
        state_d = state_q;
        ones_d  = digit_ones;
        tens_d  = digit_tens;
        value_d = value;
        valid_d = 1'b0;
        pat_d   = 1'b0;
        seq_d   = 1'b0;
        if (sample) begin
            if (ones_ok && tens_ok) begin
                valid_d = 1'b1;
                ones_d  = ones_dec;
                tens_d  = tens_dec;
                value_d = new_value;
                state_d = TRACK;
                // A break while tracking still loads the new value so the
                // checker resynchronises instead of flagging every sample.
                if (state_q == TRACK && new_value != expected)
                    seq_d = 1'b1;
            end else begin
                pat_d   = 1'b1;
                state_d = SYNC;
            end
        end
    end

    always_comb begin
        err_d = err_count;
        if (clr_err)
            err_d = '0;
        else if ((pat_d || seq_d) && err_count != '1)
            err_d = err_count + ERR_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= SYNC;
            digit_ones <= '0;
            digit_tens <= '0;
            value      <= '0;
            valid      <= 1'b0;
            pat_err    <= 1'b0;
            seq_err    <= 1'b0;
            err_count  <= '0;
        end else begin
            state_q    <= state_d;
            digit_ones <= ones_d;
            digit_tens <= tens_d;
            value      <= value_d;
            valid      <= valid_d;
            pat_err    <= pat_d;
            seq_err    <= seq_d;
            err_count  <= err_d;
        end
    end

    assign locked = (state_q == TRACK);

endmodule

// File: tb/tb_seg_pair_checker.sv
// ---------------------------------------------------------------------------
// tb_seg_pair_checker
//   Self-checking bench for seg_pair_checker. Two instances share stimulus:
//   one with ERR_W=8 and one with ERR_W=2 to exercise counter saturation.
//   A behavioural model (table lookup plus integer arithmetic) predicts
//   every output after each cycle.
// ---------------------------------------------------------------------------
module tb_seg_pair_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sample = 1'b0;
    logic       clr_err = 1'b0;
    logic [6:0] seg_ones = '0;
    logic [6:0] seg_tens = '0;

    logic [3:0] a_ones, a_tens, b_ones, b_tens;
    logic [6:0] a_value, b_value;
    logic       a_valid, a_pat, a_seq, a_locked;
    logic       b_valid, b_pat, b_seq, b_locked;
    logic [7:0] a_err;
    logic [1:0] b_err;

    seg_pair_checker #(.ERR_W(8)) dut (
        .clk(clk), .rst(rst), .sample(sample), .seg_ones(seg_ones),
        .seg_tens(seg_tens), .clr_err(clr_err), .digit_ones(a_ones),
        .digit_tens(a_tens), .value(a_value), .valid(a_valid),
        .pat_err(a_pat), .seq_err(a_seq), .locked(a_locked), .err_count(a_err)
    );

    seg_pair_checker #(.ERR_W(2)) dut_w2 (
        .clk(clk), .rst(rst), .sample(sample), .seg_ones(seg_ones),
        .seg_tens(seg_tens), .clr_err(clr_err), .digit_ones(b_ones),
        .digit_tens(b_tens), .value(b_value), .valid(b_valid),
        .pat_err(b_pat), .seq_err(b_seq), .locked(b_locked), .err_count(b_err)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Logical segment patterns, 1 = lit, {g,f,e,d,c,b,a}
    logic [6:0] seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                 7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                 7'b1111111, 7'b1101111};

    function automatic int seg_lookup(input logic [6:0] p);
        for (int i = 0; i < 10; i++)
            if (seg_tab[i] == p) return i;
        return -1;
    endfunction

    function automatic logic [6:0] phys(input logic [6:0] p);
`ifdef SEG_ACTIVE_LOW_EN
        return ~p;
`else
        return p;
`endif
    endfunction

    // Reference model state
    bit m_ref = 0;
    int m_val = 0, m_ones = 0, m_tens = 0;
    int m_err8 = 0, m_err2 = 0;
    bit e_valid = 0, e_pat = 0, e_seq = 0;
    int tally_valid = 0, tally_seq = 0;

    task automatic model_reset();
        m_ref = 0; m_val = 0; m_ones = 0; m_tens = 0;
        m_err8 = 0; m_err2 = 0;
        e_valid = 0; e_pat = 0; e_seq = 0;
    endtask

    task automatic model_step(input bit smp, input logic [6:0] po, input logic [6:0] pt, input bit clr);
        int d_o, d_t, v;
        bit err_ev;
        e_valid = 0; e_pat = 0; e_seq = 0;
        if (smp) begin
            d_o = seg_lookup(po);
            d_t = seg_lookup(pt);
            if (d_o >= 0 && d_t >= 0) begin
                v = d_t * 10 + d_o;
                e_valid = 1;
                e_seq = m_ref && (v != (m_val + 1) % 100);
                m_val = v; m_ones = d_o; m_tens = d_t; m_ref = 1;
            end else begin
                e_pat = 1;
                m_ref = 0;
            end
        end
        err_ev = e_pat || e_seq;
        if (clr) begin
            m_err8 = 0; m_err2 = 0;
        end else if (err_ev) begin
            if (m_err8 < 255) m_err8++;
            if (m_err2 < 3) m_err2++;
        end
    endtask

    task automatic compare_all(input string ctx);
        check({ctx, ".valid"},   a_valid,  e_valid);
        check({ctx, ".pat_err"}, a_pat,    e_pat);
        check({ctx, ".seq_err"}, a_seq,    e_seq);
        check({ctx, ".locked"},  a_locked, m_ref);
        check({ctx, ".value"},   a_value,  m_val);
        check({ctx, ".ones"},    a_ones,   m_ones);
        check({ctx, ".tens"},    a_tens,   m_tens);
        check({ctx, ".err8"},    a_err,    m_err8);
        check({ctx, ".w2.value"},  b_value, m_val);
        check({ctx, ".w2.flags"},  {b_valid, b_pat, b_seq, b_locked},
                                   {e_valid, e_pat, e_seq, m_ref});
        check({ctx, ".w2.digits"}, {b_tens, b_ones}, {m_tens[3:0], m_ones[3:0]});
        check({ctx, ".err2"},    b_err,    m_err2);
    endtask

    task automatic drive_cycle(input string ctx, input bit smp, input logic [6:0] po,
                               input logic [6:0] pt, input bit clr);
        @(negedge clk);
        sample   = smp;
        seg_ones = phys(po);
        seg_tens = phys(pt);
        clr_err  = clr;
        @(posedge clk);
        #1;
        model_step(smp, po, pt, clr);
        compare_all(ctx);
        if (a_valid) tally_valid++;
        if (a_seq)   tally_seq++;
        sample  = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic sample_val(input string ctx, input int v);
        drive_cycle(ctx, 1'b1, seg_tab[v % 10], seg_tab[v / 10], 1'b0);
    endtask

    task automatic async_reset(input string ctx);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        model_reset();
        compare_all(ctx);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int r, v;
        logic [6:0] junk;

        // Reset state
        repeat (2) @(negedge clk);
        model_reset();
        compare_all("reset");
        rst = 1'b1;

        // 0 then 1
        sample_val("first0", 0);
        sample_val("first1", 1);
        drive_cycle("idle", 1'b0, '0, '0, 1'b0);

        // Full sweep 00..99..00
        async_reset("sweep_rst");
        tally_valid = 0; tally_seq = 0;
        for (int i = 0; i <= 100; i++) sample_val("sweep", i % 100);
        check("sweep.valid_count", tally_valid, 101);
        check("sweep.seq_count", tally_seq, 0);
        check("sweep.err", a_err, 0);

        // Sequence break and resync
        async_reset("jump_rst");
        sample_val("jump42", 42);
        sample_val("jump45", 45);
        check("jump.err1", a_err, 1);
        sample_val("jump46", 46);

        // Illegal pattern loses lock; next legal relocks
        sample_val("pat17", 17);
        drive_cycle("pat_bad", 1'b1, 7'b1111110, seg_tab[1], 1'b0);
        check("pat_bad.value", a_value, 17);
        sample_val("pat30", 30);

        // Both digits illegal, saturation at ERR_W=2, clear wins
        async_reset("sat_rst");
        drive_cycle("both_bad", 1'b1, 7'b0000000, 7'b1000000, 1'b0);
        check("both_bad.err", a_err, 1);
        for (int i = 0; i < 4; i++)
            drive_cycle("sat", 1'b1, 7'b0000000, seg_tab[3], 1'b0);
        check("sat.err2", b_err, 3);
        drive_cycle("clr_wins", 1'b1, 7'b0000000, seg_tab[0], 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(99, 0);
            if (r < 65)      v = (m_val + 1) % 100;
            else if (r < 80) v = $urandom_range(99, 0);
            else             v = -1;
            if (r >= 95) begin
                drive_cycle("rnd_idle", 1'b0, 7'($urandom), 7'($urandom), $urandom_range(9, 0) == 0);
            end else if (v < 0) begin
                junk = 7'($urandom);
                drive_cycle("rnd_bad", 1'b1, junk, seg_tab[$urandom_range(9, 0)], $urandom_range(19, 0) == 0);
            end else begin
                drive_cycle("rnd", 1'b1, seg_tab[v % 10], seg_tab[v / 10], $urandom_range(29, 0) == 0);
            end
        end

        // Reset mid-stream, then relock at 0
        sample_val("pre63", 62);
        sample_val("at63", 63);
        async_reset("mid_rst");
        check("mid_rst.locked", a_locked, 0);
        sample_val("relock0", 0);
        check("relock0.valid", a_valid, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
